vid_pattern_gen: RTL and testbench
==================================

# vid_pattern_gen

Synthesizable video stream source. It produces IMG_W x IMG_H frames with blanking, active-high hsync/vsync/de, and a 24-bit pixel bus. Each frame is black with one white rectangle whose position and size are programmable. It drives the de/hsync/vsync/pixel input of the median, centroid, bounding-box and visualisation chain, in hardware bring-up and in self-checking benches, in place of the file-based HDMI input model.

## Interface
Parameters:
- IMG_W, 64, active pixels per line
- IMG_H, 64, active lines per frame
- H_FP, 4, horizontal front porch (cycles)
- H_SYNC, 8, hsync width (cycles)
- H_BP, 4, horizontal back porch (cycles)
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 2, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; sampled only at frame boundaries
- obj_x  in  11  rectangle left column
- obj_y  in  11  rectangle top line
- obj_w  in  11  rectangle width; 0 means no rectangle
- obj_h  in  11  rectangle height; 0 means no rectangle
- de_out  out  1  data enable
- hsync_out  out  1  horizontal sync, active high
- vsync_out  out  1  vertical sync, active high
- pixel_out  out  24  {R,G,B}
- frame_start_out  out  1  one-cycle pulse coincident with pixel (0,0)

## Operation
- H_TOTAL = IMG_W+H_FP+H_SYNC+H_BP (80 by default).
- V_TOTAL = IMG_H+V_FP+V_SYNC+V_BP (70 by default).
- Counters: h_cnt runs 0..H_TOTAL-1; v_cnt runs 0..V_TOTAL-1. v_cnt increments when h_cnt wraps.
- Line order: active, front porch, sync, back porch. Frame order is the same, in whole lines.
- FSM states:
  - IDLE: counters held at 0; all outputs 0. On an edge with enable=1: go to RUN, set h=0, v=0, latch obj_* into shadow registers.
  - RUN: counters advance every cycle. At h=H_TOTAL-1, v=V_TOTAL-1:
    - enable=1: wrap to (0,0) and relatch obj_*.
    - enable=0: go to IDLE.
- Deasserting enable mid-frame has no effect until the frame completes. A started frame is always emitted whole.
- Decode, on counters registered into the outputs:
  - de = (h < IMG_W) && (v < IMG_H)
  - hsync = IMG_W+H_FP <= h < IMG_W+H_FP+H_SYNC, on every line, blanking lines included
  - vsync = IMG_H+V_FP <= v < IMG_H+V_FP+V_SYNC, for whole lines
- Pixel value:
  - 24'hFFFFFF when de=1 and shadow_x <= h < shadow_x+shadow_w and shadow_y <= v < shadow_y+shadow_h.
  - 24'h000000 otherwise, including all blanking.
- Sums use 12-bit arithmetic, so there is no wrap. A rectangle extending past the image is clipped; there is no wrap to column or line 0.
- Changes to obj_* during a frame affect only the next frame. The shadow registers are loaded only at frame start.

## Timing
- Reset: with rst_n=0, state is IDLE, counters are 0, and de_out, hsync_out, vsync_out, pixel_out and frame_start_out are 0 immediately (asynchronously).
- Assertion of rst_n mid-frame aborts the frame at once. There is no partial-frame recovery.
- Latency:
  - Edge N: IDLE samples enable=1.
  - Edge N+1: outputs show pixel (0,0): de_out=1 and frame_start_out=1.
  - All outputs are registered. They lag the counter by exactly one cycle and share a common alignment.
- Frame period: H_TOTAL*V_TOTAL cycles (5600 by default), back to back while enable=1.
- hsync pulse: H_SYNC cycles, starting H_FP cycles after the last de of a line.
- vsync pulse: V_SYNC*H_TOTAL cycles.
- frame_start_out is high for exactly one cycle per frame.

## Test plan
- Defaults, rectangle (10,20,8,4), enable=1 for 2 frames:
  - Per frame: 4096 de cycles, 32 white pixels, 70 hsync pulses of 8 cycles, 1 vsync pulse of 160 cycles.
  - Period 5600 cycles.
  - The downstream bounding box reports (10,20)-(17,23).
- Clipping, rectangle (60,62,10,10): 4x2 = 8 white pixels, at columns 60..63 and lines 62..63. No white in blanking or wrapped to column 0.
- Zero-size rectangle, obj_w=0 with obj_h=5: 0 white pixels; sync timing unchanged.
- Mid-frame change: obj_x changes from 10 to 30 at line 30. The current frame keeps x=10 throughout; the next frame shows x=30.
- Enable dropped at line 10: the frame completes all 5600 cycles, then outputs stay 0. Re-raising enable produces frame_start_out exactly 2 edges later.
- rst_n low at line 40 for 3 cycles: outputs go to 0 without waiting for a clock edge. After release with enable=1, a fresh frame starts at (0,0) with frame_start_out pulsing.

Source files
------------

// File: rtl/vid_pattern_gen.sv
// Test-pattern video source: black IMG_W x IMG_H frames with one programmable white
// rectangle, full h/v blanking and active-high syncs, all outputs registered.
module vid_pattern_gen #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int H_FP   = 4,
  parameter int H_SYNC = 8,
  parameter int H_BP   = 4,
  parameter int V_FP   = 2,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] obj_x,
  input  logic [10:0] obj_y,
  input  logic [10:0] obj_w,
  input  logic [10:0] obj_h,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out,
  output logic        frame_start_out
);

  localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(IMG_W);
  localparam logic [11:0] V_ACT  = 12'(IMG_H);
  localparam logic [11:0] HS_BEG = 12'(IMG_W + H_FP);
  localparam logic [11:0] HS_END = 12'(IMG_W + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(IMG_H + V_FP);
  localparam logic [11:0] VS_END = 12'(IMG_H + V_FP + V_SYNC);

  // Rectangle kept as half-open bounds; ends are 12 bits so x+w never wraps.
  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] x1;
    logic [11:0] y0;
    logic [11:0] y1;
  } rect_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  rect_t       rect;
  rect_t       rect_nxt;

  logic de_c, hs_c, vs_c, fs_c, in_rect;

  always_comb begin
    rect_nxt    = '0;
    rect_nxt.x0 = {1'b0, obj_x};
    rect_nxt.x1 = {1'b0, obj_x} + {1'b0, obj_w};
    rect_nxt.y0 = {1'b0, obj_y};
    rect_nxt.y1 = {1'b0, obj_y} + {1'b0, obj_h};
  end

  // Clipping falls out of gating the rectangle with de.
  always_comb begin
    de_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_c    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_c    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    fs_c    = (h_cnt == '0) && (v_cnt == '0);
    in_rect = (h_cnt >= rect.x0) && (h_cnt < rect.x1) &&
              (v_cnt >= rect.y0) && (v_cnt < rect.y1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      h_cnt           <= '0;
      v_cnt           <= '0;
      rect            <= '0;
      de_out          <= 1'b0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      pixel_out       <= '0;
      frame_start_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          de_out          <= 1'b0;
          hsync_out       <= 1'b0;
          vsync_out       <= 1'b0;
          pixel_out       <= '0;
          frame_start_out <= 1'b0;
          h_cnt           <= '0;
          v_cnt           <= '0;
          if (enable) begin
            state <= S_RUN;
            rect  <= rect_nxt;
          end
        end
        S_RUN: begin
          de_out          <= de_c;
          hsync_out       <= hs_c;
          vsync_out       <= vs_c;
          pixel_out       <= (de_c && in_rect) ? 24'hFFFFFF : 24'h000000;
          frame_start_out <= fs_c;
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              // enable is only honoured here, so a started frame always completes
              v_cnt <= '0;
              if (enable) rect  <= rect_nxt;
              else        state <= S_IDLE;
            end else begin
              v_cnt <= v_cnt + 12'd1;
            end
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Frame-level scoreboard bench for vid_pattern_gen: expected frame statistics are
// queued as each frame is requested and checked against what the outputs show.
module tb_vid_pattern_gen;

  localparam int IMG_W   = 64;
  localparam int IMG_H   = 64;
  localparam int H_FP    = 4;
  localparam int H_SYNC  = 8;
  localparam int H_BP    = 4;
  localparam int V_FP    = 2;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 2;
  localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [10:0] obj_x, obj_y, obj_w, obj_h;
  logic        de_out, hsync_out, vsync_out, frame_start_out;
  logic [23:0] pixel_out;

  vid_pattern_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .obj_x           (obj_x),
    .obj_y           (obj_y),
    .obj_w           (obj_w),
    .obj_h           (obj_h),
    .de_out          (de_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .pixel_out       (pixel_out),
    .frame_start_out (frame_start_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int white;
    int x0;
    int y0;
    int x1;
    int y1;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string tag, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h);
    exp_t e;
    int xe, ye;
    xe = (x + w > IMG_W) ? IMG_W : x + w;
    ye = (y + h > IMG_H) ? IMG_H : y + h;
    if (w == 0 || h == 0 || x >= IMG_W || y >= IMG_H) begin
      e = '{white: 0, x0: 9999, y0: 9999, x1: -1, y1: -1};
    end else begin
      e = '{white: (xe - x) * (ye - y), x0: x, y0: y, x1: xe - 1, y1: ye - 1};
    end
    sb.push_back(e);
  endtask

  task automatic idle_chk(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if ({de_out, hsync_out, vsync_out, frame_start_out} != 4'b0 || pixel_out != 24'h0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Waits for frame_start_out, then observes one full frame period.
  task automatic capture(input string tag, input int drop_at, input int chg_at,
                         input logic [10:0] chg_x, output int waited);
    exp_t e;
    int de_n, wh, x0, y0, x1, y1, col, line;
    int hs_n, hs_rise, bad_hw, bad_hp, vs_n, vs_p, vs_rise, fs_n, bad_pix;
    logic pde, phs, pvs;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!frame_start_out && waited < 3 * FRAME);
    if (!frame_start_out) begin
      chk($sformatf("%s.start_timeout", tag), 0, 1);
      return;
    end
    de_n = 0; wh = 0; x0 = 9999; y0 = 9999; x1 = -1; y1 = -1; col = 0; line = 0;
    hs_n = 0; hs_rise = 0; bad_hw = 0; bad_hp = 0; vs_n = 0; vs_p = 0; vs_rise = -1;
    fs_n = 0; bad_pix = 0; pde = 0; phs = 0; pvs = 0;
    for (int idx = 0; idx < FRAME; idx++) begin
      if (idx > 0) begin
        @(posedge clk); #1;
      end
      if (frame_start_out) fs_n++;
      if (de_out) begin
        if (pixel_out == 24'hFFFFFF) begin
          wh++;
          if (col < x0) x0 = col;
          if (col > x1) x1 = col;
          if (line < y0) y0 = line;
          if (line > y1) y1 = line;
        end
        col++;
        de_n++;
      end else if (pde) begin
        line++;
        col = 0;
      end
      if (pixel_out != 24'h0 && (!de_out || pixel_out != 24'hFFFFFF)) bad_pix++;
      if (hsync_out && !phs) begin
        hs_n++;
        hs_rise = idx;
        if (idx % H_TOTAL != IMG_W + H_FP) bad_hp++;
      end
      if (!hsync_out && phs && (idx - hs_rise) != H_SYNC) bad_hw++;
      if (vsync_out) vs_n++;
      if (vsync_out && !pvs) begin
        vs_p++;
        vs_rise = idx;
      end
      pde = de_out; phs = hsync_out; pvs = vsync_out;
      if (idx == drop_at) enable = 1'b0;
      if (idx == chg_at) obj_x = chg_x;
    end
    chk($sformatf("%s.de_cycles", tag), de_n, IMG_W * IMG_H);
    chk($sformatf("%s.lines", tag), line, IMG_H);
    chk($sformatf("%s.fs_pulses", tag), fs_n, 1);
    chk($sformatf("%s.hs_pulses", tag), hs_n, V_TOTAL);
    chk($sformatf("%s.hs_pos_bad", tag), bad_hp, 0);
    chk($sformatf("%s.hs_width_bad", tag), bad_hw, 0);
    chk($sformatf("%s.vs_cycles", tag), vs_n, V_SYNC * H_TOTAL);
    chk($sformatf("%s.vs_pulses", tag), vs_p, 1);
    chk($sformatf("%s.vs_start", tag), vs_rise, (IMG_H + V_FP) * H_TOTAL);
    chk($sformatf("%s.bad_pixels", tag), bad_pix, 0);
    if (sb.size() == 0) begin
      chk($sformatf("%s.sb_empty", tag), 0, 1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("%s.white", tag), wh, e.white);
    chk($sformatf("%s.bb_x0", tag), x0, e.x0);
    chk($sformatf("%s.bb_y0", tag), y0, e.y0);
    chk($sformatf("%s.bb_x1", tag), x1, e.x1);
    chk($sformatf("%s.bb_y1", tag), y1, e.y1);
  endtask

  initial begin
    int w;
    rst_n  = 1'b0;
    enable = 1'b0;
    obj_x  = '0; obj_y = '0; obj_w = '0; obj_h = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.de", int'(de_out), 0);
    chk("rst.hsync", int'(hsync_out), 0);
    chk("rst.vsync", int'(vsync_out), 0);
    chk("rst.pixel", int'(pixel_out), 0);
    chk("rst.fs", int'(frame_start_out), 0);
    rst_n = 1'b1;
    idle_chk("idle_en0", 50);

    // two back-to-back frames, enable dropped at line 10 of the second
    obj_x = 11'd10; obj_y = 11'd20; obj_w = 11'd8; obj_h = 11'd4;
    enable = 1'b1;
    push_rect(10, 20, 8, 4);
    push_rect(10, 20, 8, 4);
    capture("rect1", -1, -1, 11'd0, w);
    chk("rect1.latency", w, 2);
    capture("rect2", 10 * H_TOTAL, -1, 11'd0, w);
    chk("rect2.period", w, 1);
    idle_chk("rect.drop_idle", 300);

    // clipping at the bottom-right corner; also re-raise latency
    obj_x = 11'd60; obj_y = 11'd62; obj_w = 11'd10; obj_h = 11'd10;
    enable = 1'b1;
    push_rect(60, 62, 10, 10);
    capture("clip", 10 * H_TOTAL, -1, 11'd0, w);
    chk("clip.latency", w, 2);
    idle_chk("clip.idle", 50);

    // zero-width rectangle
    obj_x = 11'd5; obj_y = 11'd5; obj_w = 11'd0; obj_h = 11'd5;
    enable = 1'b1;
    push_rect(5, 5, 0, 5);
    capture("zero", 10 * H_TOTAL, -1, 11'd0, w);
    chk("zero.latency", w, 2);
    idle_chk("zero.idle", 50);

    // obj_x changed mid-frame at line 30 only affects the following frame
    obj_x = 11'd10; obj_y = 11'd20; obj_w = 11'd8; obj_h = 11'd4;
    enable = 1'b1;
    push_rect(10, 20, 8, 4);
    push_rect(30, 20, 8, 4);
    capture("chgA", -1, 30 * H_TOTAL, 11'd30, w);
    chk("chgA.latency", w, 2);
    capture("chgB", 10 * H_TOTAL, -1, 11'd0, w);
    chk("chgB.period", w, 1);
    idle_chk("chg.idle", 50);

    // asynchronous reset at line 40, then a fresh frame
    obj_x = 11'd10;
    enable = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!frame_start_out && w < 100);
    chk("rst_mid.fs_seen", int'(frame_start_out), 1);
    repeat (40 * H_TOTAL) @(posedge clk);
    #1;
    chk("rst_mid.pre_de", int'(de_out), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.async", int'({de_out, hsync_out, vsync_out, frame_start_out, pixel_out}), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid.held", int'({de_out, hsync_out, vsync_out, frame_start_out, pixel_out}), 0);
    rst_n = 1'b1;
    push_rect(10, 20, 8, 4);
    capture("post_rst", 10 * H_TOTAL, -1, 11'd0, w);
    chk("post_rst.latency", w, 2);
    idle_chk("post_rst.idle", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
